// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared types and default constants for the push-button debouncer
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    SETTLE_HIGH = 2'd1,
    HELD_HIGH   = 2'd2,
    SETTLE_LOW  = 2'd3
  } db_state_t;

  localparam int DEF_STABLE_CYCLES = 1_000_000;
  localparam int DEF_CNT_WIDTH     = 20;
  localparam int DEF_PRESS_WIDTH   = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous board input
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced level, press/release pulses and wrapping press counter
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int PRESS_WIDTH   = DEF_PRESS_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn,
  output logic                   o_btn,
  output logic                   o_press,
  output logic                   o_release,
  output logic [PRESS_WIDTH-1:0] o_press_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 s;
  db_state_t            state;
  logic [CNT_WIDTH-1:0] cnt;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn),
    .o_q     (s)
  );

  // A reversal inside either settle state drops back to the held state and discards the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE_LOW;
      cnt           <= '0;
      o_btn         <= 1'b0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
      o_press_count <= '0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= SETTLE_HIGH;
            cnt   <= '0;
          end
        end
        SETTLE_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= HELD_HIGH;
            cnt           <= '0;
            o_btn         <= 1'b1;
            o_press       <= 1'b1;
            o_press_count <= o_press_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD_HIGH: begin
          if (!s) begin
            state <= SETTLE_LOW;
            cnt   <= '0;
          end
        end
        SETTLE_LOW: begin
          if (s) begin
            state <= HELD_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            o_btn     <= 1'b0;
            o_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
